// File: rtl/uart_apb_initiator.sv
// APB3 initiator that configures a CoreUARTapb-style UART after reset, then polls
// its status register and moves bytes between client valid/ready streams and TX/RX data.
module uart_apb_initiator #(
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter logic [2:0]  FRAME_CFG  = 3'b001,
  parameter logic [2:0]  BAUD_FRAC  = 3'd0
) (
  input  logic       PCLK,
  input  logic       PRESET,
  output logic [4:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       cfg_done,
  output logic       par_err,
  output logic       ovf_err,
  output logic       frm_err,
  output logic       slv_err,
  input  logic       err_clr
);

  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;
  localparam logic [4:0] ADDR_CTRL3  = 5'h14;

  typedef enum logic [1:0] {PH_IDLE = 2'd0, PH_SETUP = 2'd1, PH_ACCESS = 2'd2} phase_t;
  typedef enum logic [2:0] {
    ST_CFG1 = 3'd0, ST_CFG2 = 3'd1, ST_CFG3 = 3'd2,
    ST_POLL = 3'd3, ST_RDRX = 3'd4, ST_WRTX = 3'd5
  } state_t;

  phase_t     phase_r, phase_nxt_s;
  state_t     state_r, state_nxt_s;
  logic       complete_s, accept_s;
  logic       psel_nxt_s, penable_nxt_s, pwrite_nxt_s;
  logic [4:0] paddr_nxt_s;
  logic [7:0] pwdata_nxt_s;
  logic       psel_r, penable_r, pwrite_r;
  logic [4:0] paddr_r;
  logic [7:0] pwdata_r;
  logic       tx_full_r, tx_full_nxt_s, tx_ready_r;
  logic [7:0] tx_hold_r;
  logic       cfg_done_r, cfg_done_nxt_s;
  logic       rx_valid_r;
  logic [7:0] rx_data_r;
  logic       par_err_r, ovf_err_r, frm_err_r, slv_err_r;
  logic       poll_done_s;

  assign complete_s  = (phase_r == PH_ACCESS) && PREADY;
  assign poll_done_s = complete_s && (state_r == ST_POLL);
  assign accept_s    = tx_valid && tx_ready_r;

  // Phase and main-state registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      phase_r <= PH_IDLE;
      state_r <= ST_CFG1;
    end else begin
      phase_r <= phase_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  // Next phase and next main state; the main state only moves on a completion edge.
  always_comb begin
    phase_nxt_s = phase_r;
    state_nxt_s = state_r;
    case (phase_r)
      PH_IDLE:   phase_nxt_s = PH_SETUP;
      PH_SETUP:  phase_nxt_s = PH_ACCESS;
      PH_ACCESS: phase_nxt_s = PREADY ? PH_IDLE : PH_ACCESS;
      default:   phase_nxt_s = PH_IDLE;
    endcase
    if (complete_s) begin
      case (state_r)
        ST_CFG1: state_nxt_s = ST_CFG2;
        ST_CFG2: state_nxt_s = ST_CFG3;
        ST_CFG3: state_nxt_s = ST_POLL;
        ST_POLL: begin
          if (PRDATA[1] && !rx_valid_r) begin
            state_nxt_s = ST_RDRX;
          end else if (PRDATA[0] && tx_full_r) begin
            state_nxt_s = ST_WRTX;
          end else begin
            state_nxt_s = ST_POLL;
          end
        end
        ST_RDRX: state_nxt_s = ST_POLL;
        ST_WRTX: state_nxt_s = ST_POLL;
        default: state_nxt_s = ST_CFG1;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Bus drive values for the coming cycle, decoded from the next phase/state.
  always_comb begin
    psel_nxt_s    = 1'b0;
    penable_nxt_s = 1'b0;
    pwrite_nxt_s  = 1'b0;
    paddr_nxt_s   = 5'h00;
    pwdata_nxt_s  = 8'h00;
    if (phase_nxt_s != PH_IDLE) begin
      psel_nxt_s    = 1'b1;
      penable_nxt_s = (phase_nxt_s == PH_ACCESS);
      case (state_nxt_s)
        ST_CFG1: begin
          paddr_nxt_s  = ADDR_CTRL1;
          pwrite_nxt_s = 1'b1;
          pwdata_nxt_s = BAUD_VALUE[7:0];
        end
        ST_CFG2: begin
          paddr_nxt_s  = ADDR_CTRL2;
          pwrite_nxt_s = 1'b1;
          pwdata_nxt_s = {BAUD_VALUE[12:8], FRAME_CFG};
        end
        ST_CFG3: begin
          paddr_nxt_s  = ADDR_CTRL3;
          pwrite_nxt_s = 1'b1;
          pwdata_nxt_s = {5'b00000, BAUD_FRAC};
        end
        ST_POLL: paddr_nxt_s = ADDR_STATUS;
        ST_RDRX: paddr_nxt_s = ADDR_RXDATA;
        ST_WRTX: begin
          paddr_nxt_s  = ADDR_TXDATA;
          pwrite_nxt_s = 1'b1;
          pwdata_nxt_s = tx_hold_r;
        end
        default: paddr_nxt_s = 5'h00;
      endcase
    end else begin
      psel_nxt_s = 1'b0;
    end
  end

  // Holding-register and configuration-done next values.
  always_comb begin
    if (complete_s && (state_r == ST_WRTX)) begin
      tx_full_nxt_s = 1'b0;
    end else if (accept_s) begin
      tx_full_nxt_s = 1'b1;
    end else begin
      tx_full_nxt_s = tx_full_r;
    end
    cfg_done_nxt_s = cfg_done_r || (complete_s && (state_r == ST_CFG3));
  end

  // Registered APB outputs.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      pwrite_r  <= 1'b0;
      paddr_r   <= 5'h00;
      pwdata_r  <= 8'h00;
    end else begin
      psel_r    <= psel_nxt_s;
      penable_r <= penable_nxt_s;
      pwrite_r  <= pwrite_nxt_s;
      paddr_r   <= paddr_nxt_s;
      pwdata_r  <= pwdata_nxt_s;
    end
  end

  // Client streams, configuration status and sticky flags (a set beats err_clr).
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_full_r  <= 1'b0;
      tx_hold_r  <= 8'h00;
      tx_ready_r <= 1'b0;
      cfg_done_r <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_data_r  <= 8'h00;
      par_err_r  <= 1'b0;
      ovf_err_r  <= 1'b0;
      frm_err_r  <= 1'b0;
      slv_err_r  <= 1'b0;
    end else begin
      tx_full_r  <= tx_full_nxt_s;
      tx_ready_r <= cfg_done_nxt_s && !tx_full_nxt_s;
      cfg_done_r <= cfg_done_nxt_s;
      if (accept_s) begin
        tx_hold_r <= tx_data;
      end
      if (complete_s && (state_r == ST_RDRX)) begin
        rx_valid_r <= 1'b1;
        rx_data_r  <= PRDATA;
      end else if (rx_ready) begin
        rx_valid_r <= 1'b0;
      end
      par_err_r <= (par_err_r && !err_clr) || (poll_done_s && PRDATA[2]);
      ovf_err_r <= (ovf_err_r && !err_clr) || (poll_done_s && PRDATA[3]);
      frm_err_r <= (frm_err_r && !err_clr) || (poll_done_s && PRDATA[4]);
      slv_err_r <= (slv_err_r && !err_clr) || (complete_s && PSLVERR);
    end
  end

  assign PSEL     = psel_r;
  assign PENABLE  = penable_r;
  assign PWRITE   = pwrite_r;
  assign PADDR    = paddr_r;
  assign PWDATA   = pwdata_r;
  assign tx_ready = tx_ready_r;
  assign rx_valid = rx_valid_r;
  assign rx_data  = rx_data_r;
  assign cfg_done = cfg_done_r;
  assign par_err  = par_err_r;
  assign ovf_err  = ovf_err_r;
  assign frm_err  = frm_err_r;
  assign slv_err  = slv_err_r;

endmodule
